ntsc_pattern_sequencer: RTL and testbench
=========================================

# ntsc_pattern_sequencer

Controller for the NTSC shield test-pattern path. It sits between the font, RGB 3-3-2 palette and color-bar generators and the NTSC encoder's `rgb` input, replacing the arithmetic sum of the three sources with a registered, band-based priority selection. It also steps through display modes at frame boundaries, either automatically every `FRAMES_PER_MODE` frames or on a manual request.

## Interface
- `FRAMES_PER_MODE`, 120: frames shown per mode in auto mode; legal range 1..255.
- `PAL_START_Y`, 9'd80: first line of the palette band.
- `BARS_START_Y`, 9'd224: first line of the color-bar band; must be greater than `PAL_START_Y`.
- `clk` in 1: 50 MHz pixel-domain clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `x` in 10: current horizontal pixel.
- `y` in 9: current vertical pixel.
- `active_video` in 1: high during visible pixels.
- `rgb_font` in 8: font generator output.
- `rgb_pal` in 8: palette generator output.
- `rgb_bars` in 8: color-bar generator output.
- `auto_en` in 1: level; 1 enables timed mode stepping.
- `advance` in 1: single-cycle pulse, already synchronised to `clk`; requests a step to the next mode.
- `rgb` out 8: selected pixel, registered.
- `mode` out 3: current mode.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Modes, stepped in this cyclic order: COMPOSITE(0) → FONT(1) → PALETTE(2) → BARS(3) → BLACK(4) → COMPOSITE.
- Mode codes 5–7 are unreachable. If one is ever decoded, it is treated as BLACK, and the next step goes to COMPOSITE.
- Pixel selection for each mode:
  - COMPOSITE: `y < PAL_START_Y` selects `rgb_font`; `PAL_START_Y <= y < BARS_START_Y` selects `rgb_pal`; `y >= BARS_START_Y` selects `rgb_bars`.
  - FONT, PALETTE and BARS: the named source over the whole frame.
  - BLACK: 8'h00.
- Blanking: whenever `active_video` = 0, the selected value is forced to 8'h00, in every mode.
- Frame boundary: detected when `y` = 0 and registered `y_prev` ≠ 0. `y_prev` resets to 9'h1FF, so the first frame after reset is detected.
- Frame counter (8 bits):
  - increments on each boundary while `auto_en` = 1;
  - on the boundary where its value is `FRAMES_PER_MODE`−1 it clears to 0 and raises an auto step;
  - clears to 0 whenever `auto_en` = 0, and on every mode change, whatever the cause.
- Manual request: an `advance` pulse sets a `pending` flag. The flag is consumed at the next frame boundary, so mode changes happen only at boundaries.
- Combining requests:
  - `pending` and an auto step at the same boundary produce exactly one step.
  - An `advance` pulse arriving in the same cycle as a boundary is consumed at that boundary.
  - Multiple `advance` pulses within one frame produce one step.
- Reset: `mode` = COMPOSITE, counter = 0, `pending` = 0, `rgb` = 8'h00, `frame_tick` = 0, `y_prev` = 9'h1FF.
- `x` is used only for pipeline alignment. No column-dependent selection is performed.

## Timing
- `rgb` has one-cycle latency: the value output at edge n+1 uses the inputs and `mode` as they stood in cycle n.
- `frame_tick`: registered, high for exactly the one cycle after the cycle in which `y` first equals 0.
- `mode` updates on the same edge that raises `frame_tick`. The pixel sampled in the boundary cycle still uses the old mode.
- Throughput is one pixel per clock, with no stalls.
- Asserting `rst_n` low mid-frame immediately clears all outputs. After release, the first boundary is detected when `y` = 0.

## Structure
- Shared package `ntsc_pkg`:
  - mode enum `MODE_COMPOSITE` .. `MODE_BLACK` (3 bits);
  - `RGB_BLACK` = 8'h00.
- One sub-module, `ntsc_frame_detect`: `y_prev` register, boundary pulse and registered `frame_tick`.
- The mode FSM, frame counter, `pending` flag and output mux stay in the top module.

## Test plan
- After reset, with `auto_en` = 0 and `active_video` = 1, run y = 10, 100, 230 with sources 8'h11 / 8'h22 / 8'h33. Expect `rgb` = 8'h11, 8'h22, 8'h33 one cycle later, and `mode` = 0.
- Pulse `advance` at y = 50, then let y wrap to 0. Expect `mode` = 1 on the `frame_tick` edge. At y = 230, expect `rgb` = 8'h11.
- Pulse `advance` three times in one frame. Expect exactly one step at the next boundary.
- Set `auto_en` = 1, `FRAMES_PER_MODE` = 2. Expect `mode` to run 0→1→2→3→4→0 on every second boundary. Pulse `advance` in the frame of an auto step: expect a single step.
- Hold `active_video` = 0 with all sources at 8'hFF, in every mode. Expect `rgb` = 8'h00.
- Assert `rst_n` low for 3 cycles mid-frame while `mode` = 3. Expect `rgb` = 0, `mode` = 0 and `frame_tick` = 0 immediately. After release, expect `frame_tick` at the next y = 0.

Source files
------------

// File: rtl/ntsc_pkg.sv
`default_nettype none
// ============================================================================
// ntsc_pkg
// Shared types and constants for the NTSC test-pattern sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package ntsc_pkg;

    // Display modes, stepped cyclically at frame boundaries
    typedef enum logic [2:0] {
        MODE_COMPOSITE = 3'd0,
        MODE_FONT      = 3'd1,
        MODE_PALETTE   = 3'd2,
        MODE_BARS      = 3'd3,
        MODE_BLACK     = 3'd4
    } mode_t;

    localparam logic [7:0] RGB_BLACK = 8'h00;

    // Successor mode; unreachable codes recover to COMPOSITE
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_COMPOSITE: n = MODE_FONT;
            MODE_FONT:      n = MODE_PALETTE;
            MODE_PALETTE:   n = MODE_BARS;
            MODE_BARS:      n = MODE_BLACK;
            default:        n = MODE_COMPOSITE;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntsc_frame_detect.sv
`default_nettype none
// ============================================================================
// ntsc_frame_detect
// Detects the frame boundary (y returns to 0) and produces a registered
// one-cycle frame_tick in the cycle after the boundary.
// Revision: 1.0 - initial release
// ============================================================================
module ntsc_frame_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] y,
    output logic       boundary,
    output logic       frame_tick
);

    logic [8:0] y_prev;

    // y_prev resets to a non-zero value so the first y==0 after reset counts
    assign boundary = (y == 9'd0) && (y_prev != 9'd0);

    // Previous-line register and registered boundary pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_prev     <= 9'h1FF;
            frame_tick <= 1'b0;
        end else begin
            y_prev     <= y;
            frame_tick <= boundary;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ntsc_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// ntsc_pattern_sequencer
// Band-based priority selection of font / palette / colour-bar sources with
// frame-synchronous mode stepping (timed auto mode or manual advance).
// Revision: 1.0 - initial release
// ============================================================================
module ntsc_pattern_sequencer
    import ntsc_pkg::*;
#(
    parameter int         FRAMES_PER_MODE = 120,
    parameter logic [8:0] PAL_START_Y     = 9'd80,
    parameter logic [8:0] BARS_START_Y    = 9'd224
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       active_video,
    input  logic [7:0] rgb_font,
    input  logic [7:0] rgb_pal,
    input  logic [7:0] rgb_bars,
    input  logic       auto_en,
    input  logic       advance,
    output logic [7:0] rgb,
    output logic [2:0] mode,
    output logic       frame_tick
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_MODE - 1);

    mode_t      mode_q;
    mode_t      mode_d;
    logic [7:0] frame_cnt;
    logic [7:0] frame_cnt_d;
    logic       pending;
    logic       pending_d;
    logic       boundary;
    logic       auto_step;
    logic       step;
    logic       pix_enable;
    logic [7:0] pix_sel;

    ntsc_frame_detect u_frame_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .y          (y),
        .boundary   (boundary),
        .frame_tick (frame_tick)
    );

    // x only travels alongside the pixel for alignment; the reduction keeps
    // it referenced while always evaluating true
    assign pix_enable = active_video & (|{x, 1'b1});

    assign mode = mode_q;

    // Mode, counter and pending-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_COMPOSITE;
            frame_cnt <= 8'd0;
            pending   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            frame_cnt <= frame_cnt_d;
            pending   <= pending_d;
        end
    end

    // Next-state: a boundary consumes any pending/same-cycle request and the
    // auto step together, yielding at most one mode step
    always_comb begin
        auto_step   = 1'b0;
        step        = 1'b0;
        mode_d      = mode_q;
        pending_d   = pending;
        frame_cnt_d = frame_cnt;

        auto_step = boundary && auto_en && (frame_cnt == LAST_FRAME);
        step      = boundary && (pending || advance || auto_step);

        if (step) begin
            mode_d = next_mode(mode_q);
        end

        if (boundary) begin
            pending_d = 1'b0;
        end else if (advance) begin
            pending_d = 1'b1;
        end

        if (!auto_en || step) begin
            frame_cnt_d = 8'd0;
        end else if (boundary) begin
            frame_cnt_d = frame_cnt + 8'd1;
        end
    end

    // Source selection by mode and vertical band, blanked outside video
    always_comb begin
        pix_sel = RGB_BLACK;
        case (mode_q)
            MODE_COMPOSITE: begin
                if (y < PAL_START_Y) begin
                    pix_sel = rgb_font;
                end else if (y < BARS_START_Y) begin
                    pix_sel = rgb_pal;
                end else begin
                    pix_sel = rgb_bars;
                end
            end
            MODE_FONT:    pix_sel = rgb_font;
            MODE_PALETTE: pix_sel = rgb_pal;
            MODE_BARS:    pix_sel = rgb_bars;
            default:      pix_sel = RGB_BLACK;
        endcase
        if (!pix_enable) begin
            pix_sel = RGB_BLACK;
        end
    end

    // Registered pixel output, one cycle behind the inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= RGB_BLACK;
        end else begin
            rgb <= pix_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntsc_pattern_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ntsc_pattern_sequencer
// Directed-vector bench; expected responses are queued per stimulus cycle and
// compared by an independent monitor one edge later.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ntsc_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = 10'd0;
    logic [8:0] y = 9'd5;
    logic       active_video = 1'b1;
    logic [7:0] rgb_font = 8'h11;
    logic [7:0] rgb_pal  = 8'h22;
    logic [7:0] rgb_bars = 8'h33;
    logic       auto_en = 1'b0;
    logic       advance = 1'b0;
    logic [7:0] rgb;
    logic [2:0] mode;
    logic       frame_tick;

    logic       ae_lvl = 1'b0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        int    er;
        int    em;
        int    et;
        string nm;
    } exp_t;

    exp_t sb[$];

    always #10 clk = ~clk;

    ntsc_pattern_sequencer #(
        .FRAMES_PER_MODE (2),
        .PAL_START_Y     (9'd80),
        .BARS_START_Y    (9'd224)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x            (x),
        .y            (y),
        .active_video (active_video),
        .rgb_font     (rgb_font),
        .rgb_pal      (rgb_pal),
        .rgb_bars     (rgb_bars),
        .auto_en      (auto_en),
        .advance      (advance),
        .rgb          (rgb),
        .mode         (mode),
        .frame_tick   (frame_tick)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One pixel cycle: drive on the falling edge, queue what must appear after
    // the next rising edge (-1 = not checked). av=0 drives all sources to FF.
    task automatic cyc(input int yy, input bit av, input bit adv,
                       input int er, input int em, input int et, input string nm);
        exp_t e;
        @(negedge clk);
        y            = 9'(yy);
        x            = x + 10'd1;
        active_video = av;
        rgb_font     = av ? 8'h11 : 8'hFF;
        rgb_pal      = av ? 8'h22 : 8'hFF;
        rgb_bars     = av ? 8'h33 : 8'hFF;
        advance      = adv;
        auto_en      = ae_lvl;
        e.er = er; e.em = em; e.et = et; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare queued expectations just after each rising edge
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.er >= 0) chk({e.nm, ".rgb"},  int'(rgb),        e.er);
                if (e.em >= 0) chk({e.nm, ".mode"}, int'(mode),       e.em);
                if (e.et >= 0) chk({e.nm, ".tick"}, int'(frame_tick), e.et);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rgb",  int'(rgb),        0);
        chk("rst.mode", int'(mode),       0);
        chk("rst.tick", int'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Composite bands, including band edges; first boundary after reset
        cyc(10,  1, 0, 8'h11, 0, 0, "band10");
        cyc(100, 1, 0, 8'h22, 0, 0, "band100");
        cyc(230, 1, 0, 8'h33, 0, 0, "band230");
        cyc(79,  1, 0, 8'h11, 0, 0, "band79");
        cyc(80,  1, 0, 8'h22, 0, 0, "band80");
        cyc(223, 1, 0, 8'h22, 0, 0, "band223");
        cyc(224, 1, 0, 8'h33, 0, 0, "band224");
        cyc(0,   1, 0, 8'h11, 0, 1, "first_bnd");
        cyc(0,   1, 0, 8'h11, 0, 0, "y0_hold");

        // Single manual advance
        cyc(50,  1, 1, 8'h11, 0, 0, "adv_pulse");
        cyc(230, 1, 0, 8'h33, 0, 0, "adv_wait");
        cyc(0,   1, 0, 8'h11, 1, 1, "adv_step");
        cyc(230, 1, 0, 8'h11, 1, 0, "font230");

        // Three advances in one frame give one step
        cyc(10,  1, 1, 8'h11, 1, 0, "adv3_a");
        cyc(100, 1, 1, 8'h11, 1, 0, "adv3_b");
        cyc(230, 1, 1, 8'h11, 1, 0, "adv3_c");
        cyc(0,   1, 0, 8'h11, 2, 1, "adv3_step");
        cyc(10,  1, 0, 8'h22, 2, 0, "pal10");
        cyc(230, 1, 0, 8'h22, 2, 0, "pal230");
        cyc(0,   1, 0, 8'h22, 2, 1, "adv3_nostep");

        // Advance in the boundary cycle is consumed there
        cyc(230, 1, 0, 8'h22, 2, 0, "advb_pre");
        cyc(0,   1, 1, 8'h22, 3, 1, "advb_step");
        cyc(230, 1, 0, 8'h33, 3, 0, "bars230");
        cyc(0,   1, 0, 8'h33, 3, 1, "advb_nostep");

        // Auto stepping every second boundary, blanking in each mode
        ae_lvl = 1'b1;
        cyc(230, 1, 0, 8'h33, 3, 0, "auto1");
        cyc(0,   1, 0, 8'h33, 3, 1, "auto2");
        cyc(150, 0, 0, 8'h00, 3, 0, "blank_bars");
        cyc(230, 1, 0, 8'h33, 3, 0, "auto4");
        cyc(0,   1, 0, 8'h33, 4, 1, "auto5");
        cyc(230, 1, 0, 8'h00, 4, 0, "auto6");
        cyc(150, 0, 0, 8'h00, 4, 0, "blank_black");
        cyc(0,   1, 0, 8'h00, 4, 1, "auto8");
        cyc(230, 1, 0, 8'h00, 4, 0, "auto9");
        cyc(0,   1, 0, 8'h00, 0, 1, "auto10");
        cyc(230, 1, 0, 8'h33, 0, 0, "auto11");
        cyc(150, 0, 0, 8'h00, 0, 0, "blank_comp");
        cyc(0,   1, 0, 8'h11, 0, 1, "auto13");
        cyc(230, 1, 0, 8'h33, 0, 0, "auto14");
        cyc(0,   1, 0, 8'h11, 1, 1, "auto15");
        cyc(230, 1, 0, 8'h11, 1, 0, "auto16");
        cyc(150, 0, 0, 8'h00, 1, 0, "blank_font");
        cyc(0,   1, 0, 8'h11, 1, 1, "auto18");
        cyc(230, 1, 0, 8'h11, 1, 0, "auto19");
        cyc(0,   1, 0, 8'h11, 2, 1, "auto20");
        cyc(230, 1, 0, 8'h22, 2, 0, "auto21");
        cyc(150, 0, 0, 8'h00, 2, 0, "blank_pal");
        cyc(0,   1, 0, 8'h22, 2, 1, "auto23");
        cyc(100, 1, 1, 8'h22, 2, 0, "auto_adv");
        cyc(230, 1, 0, 8'h22, 2, 0, "auto25");
        cyc(0,   1, 0, 8'h22, 3, 1, "auto_adv_step");
        cyc(230, 1, 0, 8'h33, 3, 0, "auto27");
        cyc(0,   1, 0, 8'h33, 3, 1, "auto_adv_once");

        // Reset mid-frame while in BARS with frame_tick high
        ae_lvl = 1'b0;
        cyc(100, 1, 0, 8'h33, 3, 0, "pre_rst");
        cyc(0,   1, 0, 8'h33, 3, 1, "pre_rst_bnd");
        @(negedge clk);
        rst_n = 1'b0;
        y     = 9'd40;
        #1;
        chk("midrst.rgb",  int'(rgb),        0);
        chk("midrst.mode", int'(mode),       0);
        chk("midrst.tick", int'(frame_tick), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc(50,  1, 0, 8'h11, 0, 0, "post_rst");
        cyc(0,   1, 0, 8'h11, 0, 1, "post_rst_bnd");
        cyc(100, 1, 0, 8'h22, 0, 0, "post_rst_pal");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
